// File: rtl/router_weight_mc_pkg.sv
// Shared definitions for the multi-channel weight router.
//   state_t       : controller states (IDLE, ISSUE, DRAIN, DONE)
//   MODE_BCAST/UCAST : encodings of the mode input
//   kernel_words(): words per filter, KERNEL_SIZE squared
package router_weight_mc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_BCAST = 1'b0;
  localparam logic MODE_UCAST = 1'b1;

  localparam int KERNEL_SIZE_DEFAULT  = 3;

  function automatic int kernel_words(input int ks);
    return ks * ks;
  endfunction

  localparam int KERNEL_WORDS_DEFAULT = kernel_words(KERNEL_SIZE_DEFAULT);

endpackage

// File: rtl/router_weight_addr_gen.sv
// Filter/word counters for the weight router write side.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : zero both counters (new transfer accepted)
//   advance     : one spad word written this cycle; step k, roll into f
//   mode        : 0 = broadcast (addr = f*W + k), 1 = unicast (addr = k)
//   addr        : spad word address for the word currently being written
//   row_onehot  : one-hot of the current filter index f
module router_weight_addr_gen
  import router_weight_mc_pkg::*;
#(
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int KERNEL_SIZE        = 3,
  parameter int NUM_ROWS           = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          advance,
  input  logic                          mode,
  output logic [ADDR_BITWIDTH_SPAD-1:0] addr,
  output logic [NUM_ROWS-1:0]           row_onehot
);

  localparam int W = kernel_words(KERNEL_SIZE);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] W_A    = ADDR_BITWIDTH_SPAD'(W);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] LAST_K = ADDR_BITWIDTH_SPAD'(W - 1);

  logic [ADDR_BITWIDTH_SPAD-1:0] f_q, f_d;
  logic [ADDR_BITWIDTH_SPAD-1:0] k_q, k_d;

  always_comb begin
    f_d = f_q;
    k_d = k_q;
    if (clear) begin
      f_d = '0;
      k_d = '0;
    end else if (advance) begin
      if (k_q == LAST_K) begin
        k_d = '0;
        f_d = f_q + 1'b1;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q <= '0;
      k_q <= '0;
    end else begin
      f_q <= f_d;
      k_q <= k_d;
    end
  end

  // f*W is kept in spad-address width; the top checks at elaboration that
  // MAX_FILT*W fits, so this product never overflows for a legal transfer.
  assign addr = (mode == MODE_UCAST) ? k_q : (f_q * W_A) + k_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign row_onehot[gi] = (f_q == ADDR_BITWIDTH_SPAD'(gi));
    end
  endgenerate

endmodule

// File: rtl/router_weight_mc.sv
// Multi-channel weight router: streams num_filt filters of KERNEL_SIZE^2
// weights from the weight GLB into the weight spads of NUM_ROWS PE rows.
//   start/mode/base_addr/num_filt : request, latched in IDLE
//   r_addr/read_req_glb_wght      : GLB read port (data returns next cycle)
//   r_data_glb_wght               : GLB read data
//   w_data/w_addr/load_en_spad    : spad write bus, zero when not writing
//   busy/done/err                 : handshake to the control unit
module router_weight_mc
  import router_weight_mc_pkg::*;
#(
  parameter int DATA_BITWIDTH      = 16,
  parameter int ADDR_BITWIDTH_GLB  = 10,
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int KERNEL_SIZE        = 3,
  parameter int NUM_ROWS           = 3,
  parameter int MAX_FILT           = 4,
  parameter int FILT_W             = $clog2(MAX_FILT + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            mode,
  input  logic [ADDR_BITWIDTH_GLB-1:0]    base_addr,
  input  logic [FILT_W-1:0]               num_filt,
  input  logic signed [DATA_BITWIDTH-1:0] r_data_glb_wght,
  output logic [ADDR_BITWIDTH_GLB-1:0]    r_addr_glb_wght,
  output logic                            read_req_glb_wght,
  output logic signed [DATA_BITWIDTH-1:0] w_data_spad,
  output logic [ADDR_BITWIDTH_SPAD-1:0]   w_addr_spad,
  output logic [NUM_ROWS-1:0]             load_en_spad,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int W     = kernel_words(KERNEL_SIZE);
  localparam int CNT_W = $clog2(MAX_FILT * W + 1);

  generate
    if (MAX_FILT * W > (1 << ADDR_BITWIDTH_SPAD)) begin : g_bad_size
      $error("router_weight_mc: MAX_FILT*KERNEL_SIZE^2 exceeds spad address range");
    end
  endgenerate

  state_t                       state_q, state_d;
  logic                         mode_q, mode_d;
  logic [CNT_W-1:0]             n_words_q, n_words_d;
  logic [CNT_W-1:0]             issue_cnt_q, issue_cnt_d;
  logic [ADDR_BITWIDTH_GLB-1:0] r_addr_q, r_addr_d;
  logic                         read_req_q, read_req_d;
  logic                         wr_valid_q, wr_valid_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic                         clear_cnt;
  logic                         start_bad;

  logic [ADDR_BITWIDTH_SPAD-1:0] gen_addr;
  logic [NUM_ROWS-1:0]           gen_row;

  assign start_bad = (num_filt == '0) ||
                     (32'(num_filt) > MAX_FILT) ||
                     ((mode == MODE_UCAST) && (32'(num_filt) > NUM_ROWS));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    n_words_d   = n_words_q;
    issue_cnt_d = issue_cnt_q;
    r_addr_d    = '0;
    read_req_d  = 1'b0;
    // GLB data arrives the cycle after a read, so the write strobe is the
    // read strobe delayed by one cycle.
    wr_valid_d  = read_req_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    clear_cnt   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            mode_d      = mode;
            n_words_d   = CNT_W'(32'(num_filt) * W);
            issue_cnt_d = CNT_W'(1);
            r_addr_d    = base_addr;
            read_req_d  = 1'b1;
            busy_d      = 1'b1;
            clear_cnt   = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        busy_d = 1'b1;
        // issue_cnt_q counts reads already on the bus, including this cycle's.
        if (issue_cnt_q == n_words_q) begin
          state_d = DRAIN;
        end else begin
          read_req_d  = 1'b1;
          r_addr_d    = r_addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_BCAST;
      n_words_q   <= '0;
      issue_cnt_q <= '0;
      r_addr_q    <= '0;
      read_req_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      n_words_q   <= n_words_d;
      issue_cnt_q <= issue_cnt_d;
      r_addr_q    <= r_addr_d;
      read_req_q  <= read_req_d;
      wr_valid_q  <= wr_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  router_weight_addr_gen #(
    .ADDR_BITWIDTH_SPAD (ADDR_BITWIDTH_SPAD),
    .KERNEL_SIZE        (KERNEL_SIZE),
    .NUM_ROWS           (NUM_ROWS)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_cnt),
    .advance    (wr_valid_q),
    .mode       (mode_q),
    .addr       (gen_addr),
    .row_onehot (gen_row)
  );

  assign r_addr_glb_wght   = r_addr_q;
  assign read_req_glb_wght = read_req_q;
  // The GLB output register is the pipeline stage for the data word; the
  // bus is forced to zero whenever no write is in progress.
  assign w_data_spad  = wr_valid_q ? r_data_glb_wght : '0;
  assign w_addr_spad  = wr_valid_q ? gen_addr : '0;
  assign load_en_spad = !wr_valid_q ? '0 :
                        (mode_q == MODE_UCAST) ? gen_row : '1;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_router_weight_mc.sv
module tb_router_weight_mc;

  localparam int W = 9;
  localparam int GLB_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [9:0]  base_addr;
  logic [2:0]  num_filt;
  logic [15:0] r_data_glb_wght;
  logic [9:0]  r_addr_glb_wght;
  logic        read_req_glb_wght;
  logic [15:0] w_data_spad;
  logic [8:0]  w_addr_spad;
  logic [2:0]  load_en_spad;
  logic        busy;
  logic        done;
  logic        err;

  logic [15:0] glb [GLB_DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  router_weight_mc dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .mode              (mode),
    .base_addr         (base_addr),
    .num_filt          (num_filt),
    .r_data_glb_wght   (r_data_glb_wght),
    .r_addr_glb_wght   (r_addr_glb_wght),
    .read_req_glb_wght (read_req_glb_wght),
    .w_data_spad       (w_data_spad),
    .w_addr_spad       (w_addr_spad),
    .load_en_spad      (load_en_spad),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  // GLB model: synchronous read, data valid the cycle after the request.
  always @(posedge clk) begin
    if (read_req_glb_wght) r_data_glb_wght <= glb[r_addr_glb_wght];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " read_req"}, 32'(read_req_glb_wght), 0);
    check({tag, " r_addr"},   32'(r_addr_glb_wght), 0);
    check({tag, " load_en"},  32'(load_en_spad), 0);
    check({tag, " w_addr"},   32'(w_addr_spad), 0);
    check({tag, " w_data"},   32'(w_data_spad), 0);
    check({tag, " busy"},     32'(busy), 0);
    check({tag, " done"},     32'(done), 0);
    check({tag, " err"},      32'(err), 0);
  endtask

  // Full transfer, checked cycle by cycle against the expected schedule:
  // word i is read in cycle i+1 and written in cycle i+2; done in cycle N+2.
  // start_at pulses start during that cycle; reset_at asserts reset then.
  task automatic run_xfer(input string name, input logic md, input int base,
                          input int nf, input int start_at, input int reset_at);
    int n = nf * W;
    int nwr = 0;
    mode      = md;
    base_addr = 10'(base);
    num_filt  = 3'(nf);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= n + 4; c++) begin
      int i = c - 2;
      bit rd = (c <= n);
      bit wr = (c >= 2) && (c <= n + 1);
      int exp_en   = 0;
      int exp_addr = 0;
      int exp_data = 0;
      string t = $sformatf("%s c%0d", name, c);
      if (wr) begin
        exp_en   = md ? (1 << (i / W)) : 7;
        exp_addr = md ? (i % W) : i;
        exp_data = int'(glb[(base + i) % GLB_DEPTH]);
        nwr++;
      end
      check({t, " read_req"}, 32'(read_req_glb_wght), 32'(rd));
      check({t, " r_addr"},   32'(r_addr_glb_wght), rd ? 32'((base + c - 1) % GLB_DEPTH) : 0);
      check({t, " load_en"},  32'(load_en_spad), 32'(exp_en));
      check({t, " w_addr"},   32'(w_addr_spad), 32'(exp_addr));
      check({t, " w_data"},   32'(w_data_spad), 32'(exp_data));
      check({t, " busy"},     32'(busy), 32'(c <= n + 1));
      check({t, " done"},     32'(done), 32'(c == n + 2));
      check({t, " err"},      32'(err), 0);
      start = (c == start_at);
      reset = (c == reset_at);
      @(posedge clk); #1;
      if (c == reset_at) begin
        start = 1'b0;
        check_quiet({name, " after reset"});
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(posedge clk); #1;
          check({name, " post-reset done"}, 32'(done), 0);
          check({name, " post-reset busy"}, 32'(busy), 0);
        end
        $display("xfer %s mode=%0d base=%0d nf=%0d aborted by reset at cycle %0d after %0d writes",
                 name, md, base, nf, c, nwr);
        return;
      end
    end
    start = 1'b0;
    $display("xfer %s mode=%0d base=%0d nf=%0d words=%0d", name, md, base, nf, nwr);
  endtask

  task automatic run_reject(input string name, input logic md, input int nf);
    mode      = md;
    base_addr = 10'd5;
    num_filt  = 3'(nf);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " err"},      32'(err), 1);
    check({name, " busy"},     32'(busy), 0);
    check({name, " read_req"}, 32'(read_req_glb_wght), 0);
    @(posedge clk); #1;
    check({name, " err drop"},  32'(err), 0);
    check({name, " busy idle"}, 32'(busy), 0);
    check({name, " no read"},   32'(read_req_glb_wght), 0);
    $display("reject %s mode=%0d nf=%0d", name, md, nf);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; num_filt = '0;
    for (int a = 0; a < GLB_DEPTH; a++) glb[a] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int a = 0; a < 9; a++) glb[a] = 16'(a + 1);
    run_xfer("bcast1", 1'b0, 0, 1, -1, -1);

    for (int a = 0; a < 27; a++) glb[16 + a] = 16'(100 + a);
    run_xfer("ucast3", 1'b1, 16, 3, -1, -1);

    run_xfer("wrap", 1'b0, 1020, 1, -1, -1);

    run_reject("nf0", 1'b0, 0);
    run_reject("ucast4", 1'b1, 4);
    run_reject("nf5", 1'b0, 5);

    run_xfer("restart_busy", 1'b0, 40, 2, 5, -1);
    run_xfer("start_in_done", 1'b1, 200, 2, 2 * W + 2, -1);
    run_xfer("reset_mid", 1'b0, 300, 2, -1, 6);
    run_xfer("after_reset", 1'b1, 310, 1, -1, -1);
    run_xfer("bcast_max", 1'b0, 1010, 4, -1, -1);

    for (int r = 0; r < 6; r++) begin
      logic md = 1'($urandom_range(0, 1));
      int nf = md ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 4));
      int base = int'($urandom_range(0, GLB_DEPTH - 1));
      run_xfer($sformatf("rand%0d", r), md, base, nf, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
